dmem_arbiter: RTL and testbench

//  Two-master round-robin arbiter sharing the single Data_Memory port.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arbiter_rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and master indices for dmem_arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin pick, combinational
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // A lone requester wins; on a tie the master that did not win last time goes.
  always_comb begin
    valid  = |req;
    winner = M_CPU;
    case (req)
      2'b01:   winner = M_CPU;
      2'b10:   winner = M_DBG;
      2'b11:   winner = ~last;
      default: winner = M_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master round-robin arbiter in front of Data_Memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t              state;
  logic                last_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-3:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rvalid_q;
  logic                busy_q;

  logic                arb_valid;
  logic                arb_winner;
  logic                accept;

  rr_arb2 u_rr_arb2 (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // A new command can only be taken while the memory port is not in use,
  // and never in a reset cycle since nothing would be latched.
  assign accept = arb_valid && !arst && ((state == IDLE) || (state == RESP));

  assign m0_gnt    = accept && (arb_winner == M_CPU);
  assign m1_gnt    = accept && (arb_winner == M_DBG);

  // Low address bits are simply not stored, so misaligned requests land on
  // the enclosing word; addr/wdata stay visible between accesses.
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_we    = (state == ACCESS) && we_q && !arst;

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign busy      = busy_q;

  // Access sequencer: latch a command, drive memory for one cycle, then respond.
  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= IDLE;
      last_q   <= M_DBG;
      owner_q  <= M_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          rvalid_q <= 2'b00;
          if (arb_valid) begin
            owner_q <= arb_winner;
            last_q  <= arb_winner;
            if (arb_winner == M_DBG) begin
              we_q    <= m1_we;
              addr_q  <= m1_addr[ADDR_W-1:2];
              wdata_q <= m1_wdata;
            end else begin
              we_q    <= m0_we;
              addr_q  <= m0_addr[ADDR_W-1:2];
              wdata_q <= m0_wdata;
            end
            state  <= ACCESS;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= mem_rdata;
          end
          rvalid_q <= (owner_q == M_DBG) ? 2'b10 : 2'b01;
          state    <= RESP;
          busy_q   <= 1'b1;
        end
        default: begin
          rvalid_q <= 2'b00;
          state    <= IDLE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] env_mem [0:63];
  assign mem_rdata = env_mem[mem_addr[7:2]];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .arst(arst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    int          acc;
    bit          owner;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  // Reference model: accepted transactions on a cycle timeline.
  txn_t        q[$];
  logic [31:0] model_mem [0:63];
  bit          m_last;
  logic [31:0] m_rdata, m_lat_addr, m_lat_wdata;
  int          cyc = 0;
  int          s_cyc;
  int          vectors = 0;
  int          errors = 0;

  logic        s_m0_gnt, s_m1_gnt, s_m0_rv, s_m1_rv, s_mem_we, s_busy;
  logic [31:0] s_m0_rdata, s_m1_rdata, s_mem_addr, s_mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, s_cyc);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    env_mem[idx]   = val;
    model_mem[idx] = val;
  endtask

  task automatic step();
    bit          acc_found, rsp_found, w;
    txn_t        a, r, t;
    logic [1:0]  rq;
    logic        e_gnt0, e_gnt1;
    @(negedge clk);
    s_cyc = cyc;
    s_m0_gnt = m0_gnt;  s_m1_gnt = m1_gnt;
    s_m0_rv = m0_rvalid; s_m1_rv = m1_rvalid;
    s_m0_rdata = m0_rdata; s_m1_rdata = m1_rdata;
    s_mem_we = mem_we; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata; s_busy = busy;
    acc_found = 0; rsp_found = 0; w = 0;
    foreach (q[i]) begin
      if (q[i].acc == cyc)     begin a = q[i]; acc_found = 1; end
      if (q[i].acc == cyc - 1) begin r = q[i]; rsp_found = 1; end
    end
    rq = {m1_req, m0_req};
    e_gnt0 = 0; e_gnt1 = 0;
    if (!arst && !acc_found && rq != 2'b00) begin
      w = (rq == 2'b11) ? !m_last : rq[1];
      if (w) e_gnt1 = 1; else e_gnt0 = 1;
    end
    chk("m0_gnt", s_m0_gnt, e_gnt0);
    chk("m1_gnt", s_m1_gnt, e_gnt1);
    chk("m0_rvalid", s_m0_rv, rsp_found && !r.owner);
    chk("m1_rvalid", s_m1_rv, rsp_found && r.owner);
    chk("m0_rdata", s_m0_rdata, m_rdata);
    chk("m1_rdata", s_m1_rdata, m_rdata);
    chk("mem_we", s_mem_we, acc_found && a.we && !arst);
    chk("mem_addr", s_mem_addr, m_lat_addr & ~32'h3);
    chk("mem_wdata", s_mem_wdata, m_lat_wdata);
    chk("busy", s_busy, acc_found || rsp_found);
    if (arst) begin
      q.delete();
      m_last = 1; m_rdata = 0; m_lat_addr = 0; m_lat_wdata = 0;
    end else begin
      if (acc_found) begin
        if (a.we) model_mem[a.addr[7:2]] = a.wdata;
        else      m_rdata = model_mem[a.addr[7:2]];
      end
      if (e_gnt0 || e_gnt1) begin
        t.acc = cyc + 1; t.owner = w;
        t.we    = w ? m1_we    : m0_we;
        t.addr  = w ? m1_addr  : m0_addr;
        t.wdata = w ? m1_wdata : m0_wdata;
        q.push_back(t);
        m_last = w; m_lat_addr = t.addr; m_lat_wdata = t.wdata;
      end
      while (q.size() > 0 && q[0].acc < cyc) void'(q.pop_front());
    end
    @(posedge clk);
    if (s_mem_we) env_mem[s_mem_addr[7:2]] = s_mem_wdata;
    #1;
    cyc++;
    if (s_m0_gnt) m0_req = 0;
    if (s_m1_gnt) m1_req = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1, ng, last_g, prev_w, maxgap, alt_bad, cnt, r0, r1, g1;
    bit got;
    arst = 1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    m_last = 1; m_rdata = 0; m_lat_addr = 0; m_lat_wdata = 0;
    for (int i = 0; i < 64; i++) preload(i, 32'h0);

    // reset state
    step(); step();
    arst = 0;
    step();
    chk("reset_busy", s_busy, 0);
    chk("reset_rdata", s_m0_rdata, 0);
    chk("reset_mem_addr", s_mem_addr, 0);

    // single read with literal latencies
    preload(4, 32'hDEADBEEF);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    step(); chk("t1_gnt", s_m0_gnt, 1);
    step(); chk("t1_mem_addr", s_mem_addr, 32'h10); chk("t1_mem_we", s_mem_we, 0);
    step(); chk("t1_rvalid", s_m0_rv, 1); chk("t1_rdata", s_m0_rdata, 32'hDEADBEEF);
    step();

    // tie straight after reset
    arst = 1; step(); arst = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h04;
    m1_req = 1; m1_we = 0; m1_addr = 32'h08;
    step(); chk("t2_m0_first", s_m0_gnt, 1); chk("t2_m1_wait", s_m1_gnt, 0);
    r0 = -1; r1 = -1; g1 = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_m0_rv && r0 < 0) r0 = s_cyc;
      if (s_m1_rv && r1 < 0) r1 = s_cyc;
      if (s_m1_gnt && g1 < 0) g1 = s_cyc;
    end
    chk("t2_m1_gnt_in_m0_resp", g1, r0);
    chk("t2_rvalid_spacing", r1 - r0, 2);

    // fairness under continuous dual request
    n0 = 0; n1 = 0; ng = 0; last_g = -1; prev_w = -1; maxgap = 0; alt_bad = 0;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 40 && ng < 10; k++) begin
      step();
      if (s_m0_gnt || s_m1_gnt) begin
        if (s_m1_gnt) n1++; else n0++;
        if (prev_w == int'(s_m1_gnt)) alt_bad++;
        prev_w = int'(s_m1_gnt);
        if (last_g >= 0 && s_cyc - last_g > maxgap) maxgap = s_cyc - last_g;
        last_g = s_cyc;
        ng++;
      end
      m0_req = 1; m1_req = 1;
    end
    m0_req = 0; m1_req = 0;
    chk("t3_m0_grants", n0, 5);
    chk("t3_m1_grants", n1, 5);
    chk("t3_alternation", alt_bad, 0);
    chk("t3_max_gap", maxgap, 2);
    step(); step(); step();

    // write then read back
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin step(); if (s_mem_we) cnt++; end
    chk("t4_we_cycles", cnt, 1);
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      step();
      if (s_m0_rv) begin got = 1; chk("t4_readback", s_m0_rdata, 32'h12345678); end
    end
    chk("t4_rvalid_seen", got, 1);
    step();

    // reset during the memory cycle of a write
    preload(12, 32'hAAAA0000);
    m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'h55555555;
    step(); chk("t5_gnt", s_m1_gnt, 1);
    arst = 1;
    step(); chk("t5_we_blocked", s_mem_we, 0); chk("t5_no_rvalid", s_m1_rv, 0);
    arst = 0;
    step();
    chk("t5_busy", s_busy, 0); chk("t5_rvalid", s_m1_rv | s_m0_rv, 0);
    chk("t5_rdata", s_m1_rdata, 0); chk("t5_mem_addr", s_mem_addr, 0);
    chk("t5_mem_wdata", s_mem_wdata, 0); chk("t5_mem_we", s_mem_we, 0);
    chk("t5_mem_kept", env_mem[12], 32'hAAAA0000);

    // misaligned read
    m0_req = 1; m0_we = 0; m0_addr = 32'h13;
    cnt = 0;
    step(); if (s_busy) cnt++;
    step(); if (s_busy) cnt++; chk("t6_mem_addr", s_mem_addr, 32'h10);
    for (int k = 0; k < 3; k++) begin step(); if (s_busy) cnt++; end
    chk("t6_busy_cycles", cnt, 2);

    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if (!m0_req && ($urandom % 2 == 0)) begin
        m0_req = 1; m0_we = 1'($urandom % 2);
        m0_addr = $urandom_range(0, 255); m0_wdata = $urandom;
      end
      if (!m1_req && ($urandom % 2 == 0)) begin
        m1_req = 1; m1_we = 1'($urandom % 2);
        m1_addr = $urandom_range(0, 255); m1_wdata = $urandom;
      end
      arst = ($urandom % 150 == 0);
      step();
    end
    arst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
